// File: rtl/acia_rx.sv
// ACIA receiver: 8-bit async serial input with holding register and flags.
// Optional parity stage is compiled in with `define ACIA_RX_PARITY_EN.
//
// Ports:
//   uart_clk     clock; res_n async active-low reset
//   rxd          async serial line, idle high, LSB first
//   rx_en        receiver enable (0 holds the FSM in IDLE)
//   parity_odd   1 = odd parity, 0 = even (parity build only)
//   rx_rd        read strobe, consumes the holding register
//   rx_data      holding register
//   rx_full      unread byte present
//   framing_err  stop bit was low for the byte in rx_data
//   parity_err   parity mismatch for the byte in rx_data
//   overrun_err  sticky: a byte completed while rx_full was set
module acia_rx #(
    parameter int unsigned BAUD_DIV = 16
) (
    input  logic       uart_clk,
    input  logic       res_n,
    input  logic       rxd,
    input  logic       rx_en,
    input  logic       parity_odd,
    input  logic       rx_rd,
    output logic [7:0] rx_data,
    output logic       rx_full,
    output logic       framing_err,
    output logic       parity_err,
    output logic       overrun_err
);

    localparam int unsigned CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef ACIA_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          stop_q, stop_d;
    logic          done_q, done_d;
    logic          pe_q, pe_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_full_q, rx_full_d;
    logic          fe_q, fe_d;
    logic          pe_out_q, pe_out_d;
    logic          ovr_q, ovr_d;
    logic          rxs;
    logic          tc;

    assign rxs = sync2_q;
    assign tc  = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        stop_d  = stop_q;
        pe_d    = pe_q;
        done_d  = 1'b0;
        if (!rx_en) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_d = START;
                        cnt_d   = HALF_M1;
                    end
                end
                START: begin
                    if (!tc) begin
                        cnt_d = cnt_q - CW'(1);
                    end else if (!rxs) begin
                        state_d = DATA;
                        cnt_d   = FULL_M1;
                        bit_d   = '0;
                    end else begin
                        // line went high again: glitch, not a start bit
                        state_d = IDLE;
                    end
                end
                DATA: begin
                    if (!tc) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        shift_d = {rxs, shift_q[7:1]};
                        cnt_d   = FULL_M1;
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef ACIA_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end
                end
`ifdef ACIA_RX_PARITY_EN
                PARITY: begin
                    if (!tc) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        pe_d    = ^shift_q ^ rxs ^ parity_odd;
                        state_d = STOP;
                        cnt_d   = FULL_M1;
                    end
                end
`endif
                STOP: begin
                    if (!tc) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        // back to IDLE now so a back-to-back start is caught
                        stop_d  = rxs;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rx_data_d = rx_data_q;
        rx_full_d = rx_full_q;
        fe_d      = fe_q;
        pe_out_d  = pe_out_q;
        ovr_d     = ovr_q;
        if (done_q) begin
            if (!rx_full_q || rx_rd) begin
                rx_data_d = shift_q;
                fe_d      = ~stop_q;
                pe_out_d  = pe_q;
                rx_full_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (rx_rd && rx_full_q) begin
            rx_full_d = 1'b0;
            ovr_d     = 1'b0;
        end
    end

    always_ff @(posedge uart_clk or negedge res_n) begin
        if (!res_n) begin
            state_q   <= IDLE;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            stop_q    <= 1'b0;
            done_q    <= 1'b0;
            pe_q      <= 1'b0;
            rx_data_q <= '0;
            rx_full_q <= 1'b0;
            fe_q      <= 1'b0;
            pe_out_q  <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= rxd;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            stop_q    <= stop_d;
            done_q    <= done_d;
            pe_q      <= pe_d;
            rx_data_q <= rx_data_d;
            rx_full_q <= rx_full_d;
            fe_q      <= fe_d;
            pe_out_q  <= pe_out_d;
            ovr_q     <= ovr_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_full     = rx_full_q;
    assign framing_err = fe_q;
    assign overrun_err = ovr_q;

`ifdef ACIA_RX_PARITY_EN
    assign parity_err = pe_out_q;
`else
    logic unused_parity;
    assign unused_parity = parity_odd ^ pe_out_q;
    assign parity_err    = 1'b0;
`endif

endmodule

// File: tb/tb_acia_rx.sv
// Randomized self-checking bench for acia_rx.
// Compares DUT outputs against a frame-level model of the holding register.
module tb_acia_rx;

    localparam int BD = 16;
`ifdef ACIA_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       uart_clk = 1'b0;
    logic       res_n = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic       rx_rd = 1'b0;
    logic [7:0] rx_data;
    logic       rx_full;
    logic       framing_err;
    logic       parity_err;
    logic       overrun_err;

    int n_checks = 0;
    int n_errors = 0;
    int lat;

    logic [7:0] m_data = 8'h00;
    logic       m_full = 1'b0;
    logic       m_fe = 1'b0;
    logic       m_pe = 1'b0;
    logic       m_ovr = 1'b0;

    acia_rx #(.BAUD_DIV(BD)) dut (
        .uart_clk   (uart_clk),
        .res_n      (res_n),
        .rxd        (rxd),
        .rx_en      (rx_en),
        .parity_odd (parity_odd),
        .rx_rd      (rx_rd),
        .rx_data    (rx_data),
        .rx_full    (rx_full),
        .framing_err(framing_err),
        .parity_err (parity_err),
        .overrun_err(overrun_err)
    );

    always #5 uart_clk = ~uart_clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data"}, 32'(rx_data), 32'(m_data));
        check({tag, ".full"}, 32'(rx_full), 32'(m_full));
        check({tag, ".fe"}, 32'(framing_err), 32'(m_fe));
        check({tag, ".pe"}, 32'(parity_err), 32'(m_pe));
        check({tag, ".ovr"}, 32'(overrun_err), 32'(m_ovr));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge uart_clk);
    endtask

    task automatic model_reset();
        m_data = 8'h00;
        m_full = 1'b0;
        m_fe   = 1'b0;
        m_pe   = 1'b0;
        m_ovr  = 1'b0;
    endtask

    // drop_bit >= 0 lowers rx_en at that frame bit; the frame is then lost
    task automatic send(input logic [7:0] b, input logic stop,
                        input logic pbit, input int drop_bit);
        logic q[$];
        int   ones;
        logic pe;
        q = {};
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(b[i]);
        if (PB != 0) q.push_back(pbit);
        q.push_back(stop);
        for (int k = 0; k < q.size(); k++) begin
            if (k == drop_bit) rx_en = 1'b0;
            rxd = q[k];
            repeat (BD) @(negedge uart_clk);
        end
        rxd = 1'b1;
        if (drop_bit < 0) begin
            ones = $countones(b) + ((PB != 0) ? int'(pbit) : 0);
            if (PB == 0) pe = 1'b0;
            else if (parity_odd) pe = (ones % 2 == 0);
            else pe = (ones % 2 == 1);
            if (!m_full) begin
                m_data = b;
                m_fe   = ~stop;
                m_pe   = pe;
                m_full = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end
        idle(24);
        rx_en = 1'b1;
    endtask

    task automatic read();
        rx_rd = 1'b1;
        @(negedge uart_clk);
        rx_rd = 1'b0;
        if (m_full) begin
            m_full = 1'b0;
            m_ovr  = 1'b0;
        end
        idle(2);
    endtask

    function automatic logic good_par(input logic [7:0] b, input logic odd);
        int ones;
        ones = $countones(b);
        return odd ? logic'(ones % 2 == 0) : logic'(ones % 2 == 1);
    endfunction

    initial begin
        int nom;
        logic [7:0] b;
        logic       st;
        logic       pb;

        idle(3);
        check_all("reset");
        res_n = 1'b1;
        rx_en = 1'b1;
        idle(5);

        nom = 2 + BD / 2 + 9 * BD + 1 + PB * BD;
        lat = 0;
        fork
            send(8'h55, 1'b1, good_par(8'h55, parity_odd), -1);
            begin
                while (!rx_full && lat < 600) begin
                    @(negedge uart_clk);
                    lat++;
                end
            end
        join
        check("latency", 32'(lat),
              32'((lat >= nom - 1 && lat <= nom + 1) ? lat : nom));
        check_all("b55");
        read();
        check_all("b55_rd");
        read();
        check_all("rd_empty");

        rxd = 1'b0;
        idle(4);
        rxd = 1'b1;
        idle(30);
        check_all("false_start");

        send(8'hA3, 1'b0, good_par(8'hA3, parity_odd), -1);
        check_all("bA3_fe");
        read();
        send(8'h0F, 1'b1, good_par(8'h0F, parity_odd), -1);
        check_all("b0F");
        read();

        send(8'h11, 1'b1, good_par(8'h11, parity_odd), -1);
        send(8'h22, 1'b1, good_par(8'h22, parity_odd), -1);
        check_all("overrun");
        read();
        check_all("overrun_rd");

`ifdef ACIA_RX_PARITY_EN
        parity_odd = 1'b1;
        send(8'h01, 1'b1, 1'b1, -1);
        check_all("par_bad");
        read();
        send(8'h01, 1'b1, 1'b0, -1);
        check_all("par_ok");
        read();
`endif

        send(8'hC6, 1'b1, 1'b0, 4);
        check_all("en_drop");

        send(8'h5A, 1'b1, good_par(8'h5A, parity_odd), -1);
        rxd = 1'b0;
        idle(BD);
        rxd = 1'b0;
        idle(BD);
        rxd = 1'b1;
        idle(BD);
        rxd = 1'b1;
        idle(BD);
        rxd = 1'b1;
        idle(BD / 2);
        res_n = 1'b0;
        #1;
        model_reset();
        check_all("mid_reset");
        idle(3);
        res_n = 1'b1;
        idle(8 * BD);
        check_all("post_reset");
        send(8'h3C, 1'b1, good_par(8'h3C, parity_odd), -1);
        check_all("b3C");
        read();

        for (int i = 0; i < 24; i++) begin
            b  = 8'($urandom);
            st = ($urandom_range(0, 3) != 0);
            parity_odd = 1'($urandom);
            pb = ($urandom_range(0, 3) != 0) ? good_par(b, parity_odd)
                                             : ~good_par(b, parity_odd);
            send(b, st, pb, -1);
            check_all("rnd");
            if ($urandom_range(0, 1) == 1) begin
                read();
                check_all("rnd_rd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
